// File: rtl/pulse_train_generator.sv
// Programmable pulse-train generator: start delay, high width, low gap and pulse count, with ready/busy/done status.
// Define PULSE_TRAIN_RETRIGGER_EN to let a start request while busy restart the train.
module pulse_train_generator #(
  parameter int   CNT_W       = 16,
  parameter int   NUM_W       = 8,
  parameter int   RESET_DELAY = 3,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] start_delay,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] gap_width,
  input  logic [NUM_W-1:0] pulse_count,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             ready_after_reset,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    RST_DLY = 3'd0,
    IDLE    = 3'd1,
    DELAY   = 3'd2,
    HIGH    = 3'd3,
    LOW     = 3'd4
  } state_t;

  state_t           state;
  logic [1:0]       rst_sync;
  logic             rst_released;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] w_lat;
  logic [CNT_W-1:0] g_lat;
  logic [NUM_W-1:0] n_lat;
  logic [NUM_W-1:0] pulse_num;
  logic [CNT_W-1:0] d_eff;
  logic [CNT_W-1:0] w_eff;
  logic [CNT_W-1:0] g_eff;
  logic [NUM_W-1:0] n_eff;
  logic             active_state;
  logic             restart;
  logic             last_pulse;

  assign state_dbg = state;

  always_comb begin
    d_eff = (start_delay == '0) ? CNT_W'(1) : start_delay;
    w_eff = (pulse_width == '0) ? CNT_W'(1) : pulse_width;
    g_eff = (gap_width   == '0) ? CNT_W'(1) : gap_width;
    n_eff = (pulse_count == '0) ? NUM_W'(1) : pulse_count;
  end

  assign active_state = (state == DELAY) || (state == HIGH) || (state == LOW);
  assign last_pulse   = (pulse_num == (n_lat - NUM_W'(1)));

  // Handshake: start is a level request sampled on each rising edge while IDLE
  // (or while busy when retrigger is built in); abort always outranks start.
`ifdef PULSE_TRAIN_RETRIGGER_EN
  assign restart = start && !abort && ((state == IDLE) || active_state);
`else
  assign restart = start && !abort && (state == IDLE);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_released = rst_sync[1];

  // cnt holds the remaining cycles of the current phase after the present one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= RST_DLY;
      cnt               <= '0;
      w_lat             <= '0;
      g_lat             <= '0;
      n_lat             <= '0;
      pulse_num         <= '0;
      pulse_out         <= IDLE_LEVEL;
      busy              <= 1'b0;
      done              <= 1'b0;
      ready_after_reset <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == RST_DLY) begin
        if (rst_released) begin
          if (cnt == CNT_W'(RESET_DELAY - 1)) begin
            ready_after_reset <= 1'b1;
            cnt               <= '0;
            state             <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end else if (active_state && abort) begin
        state     <= IDLE;
        pulse_out <= IDLE_LEVEL;
        busy      <= 1'b0;
        cnt       <= '0;
      end else if (restart) begin
        w_lat     <= w_eff;
        g_lat     <= g_eff;
        n_lat     <= n_eff;
        pulse_num <= '0;
        busy      <= 1'b1;
        if (d_eff == CNT_W'(1)) begin
          state     <= HIGH;
          pulse_out <= ~IDLE_LEVEL;
          cnt       <= w_eff - CNT_W'(1);
        end else begin
          state     <= DELAY;
          pulse_out <= IDLE_LEVEL;
          cnt       <= d_eff - CNT_W'(2);
        end
      end else begin
        case (state)
          DELAY: begin
            if (cnt == '0) begin
              state     <= HIGH;
              pulse_out <= ~IDLE_LEVEL;
              cnt       <= w_lat - CNT_W'(1);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          HIGH: begin
            if (cnt == '0) begin
              pulse_out <= IDLE_LEVEL;
              if (last_pulse) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= LOW;
                cnt   <= g_lat - CNT_W'(1);
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          LOW: begin
            if (cnt == '0) begin
              state     <= HIGH;
              pulse_out <= ~IDLE_LEVEL;
              cnt       <= w_lat - CNT_W'(1);
              pulse_num <= pulse_num + NUM_W'(1);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  a_done_single: assert property (@(posedge clk) disable iff (!reset) done |=> !done);
  a_busy_done:   assert property (@(posedge clk) disable iff (!reset) !(busy && done));
  a_idle_level:  assert property (@(posedge clk) disable iff (!reset) !busy |-> (pulse_out == IDLE_LEVEL));

endmodule
